cpe_fetch_unit: RTL

CPE_FETCH_UNIT -- requirements
Module: cpe_fetch_unit

---
 rtl/cpe_fetch_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cpe_fetch_unit.sv
// Instruction prefetch unit: issues word fetches, queues in-order responses in a FIFO
// with their PCs, and handles redirects by flushing and draining. Define CPE_FETCH_MISALIGN_EN for the FAULT state.
module cpe_fetch_unit #(
    parameter int          ADDR_W   = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_w_i,
    input  logic              res_w_i_l,
    output logic              imem_req_w_o_h,
    output logic [ADDR_W-1:0] imem_addr_w_o,
    input  logic              imem_gnt_w_i_h,
    input  logic              imem_rvalid_w_i_h,
    input  logic [31:0]       imem_rdata_w_i,
    input  logic              redirect_w_i_h,
    input  logic [ADDR_W-1:0] redirect_pc_w_i,
    output logic              instr_valid_w_o_h,
    output logic [31:0]       instr_w_o,
    output logic [ADDR_W-1:0] instr_pc_w_o,
    input  logic              instr_ready_w_i_h,
    output logic              fault_w_o_h
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

`ifdef CPE_FETCH_MISALIGN_EN
    typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_DRAIN} state_t;
`endif

    state_t            state, settle_st;
    logic [ADDR_W-1:0] fetch_pc, redir_pc;
    logic [CW-1:0]     out_cnt, fifo_cnt, disc_cnt, disc_load;
    logic [PW-1:0]     pcq_wp, pcq_rp, fifo_wp, fifo_rp;
    logic [ADDR_W-1:0] pcq     [DEPTH];
    logic [ADDR_W-1:0] fifo_pc [DEPTH];
    logic [31:0]       fifo_instr [DEPTH];
    logic              grant, rsp, push, pop;

    assign redir_pc = {redirect_pc_w_i[ADDR_W-1:2], 2'b00};

`ifdef CPE_FETCH_MISALIGN_EN
    logic fault_pend, redir_mis, fault_nxt;
    assign redir_mis   = |redirect_pc_w_i[1:0];
    assign fault_nxt   = redirect_w_i_h ? redir_mis : fault_pend;
    // where the unit lands once nothing is left to discard
    assign settle_st   = fault_nxt ? S_FAULT : S_FETCH;
    assign fault_w_o_h = (state == S_FAULT);
`else
    logic unused_lo;
    assign unused_lo   = ^redirect_pc_w_i[1:0];
    assign settle_st   = S_FETCH;
    assign fault_w_o_h = 1'b0;
`endif

    // held low while reset is asserted so the bus sees no request during reset
    assign imem_req_w_o_h = res_w_i_l && (state == S_FETCH) &&
                            (({1'b0, fifo_cnt} + {1'b0, out_cnt}) < DEPTH_C);
    assign imem_addr_w_o  = fetch_pc;
    assign grant          = imem_req_w_o_h && imem_gnt_w_i_h;
    assign rsp            = imem_rvalid_w_i_h && (state == S_FETCH);
    assign push           = rsp && !redirect_w_i_h;
    assign pop            = instr_valid_w_o_h && instr_ready_w_i_h;
    assign disc_load      = out_cnt + CW'(grant) - CW'(rsp);

    assign instr_valid_w_o_h = (fifo_cnt != '0);
    assign instr_w_o         = fifo_instr[fifo_rp];
    assign instr_pc_w_o      = fifo_pc[fifo_rp];

    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            state    <= S_FETCH;
            fetch_pc <= RESET_PC[ADDR_W-1:0];
            out_cnt  <= '0;
            fifo_cnt <= '0;
            disc_cnt <= '0;
            pcq_wp   <= '0;
            pcq_rp   <= '0;
            fifo_wp  <= '0;
            fifo_rp  <= '0;
`ifdef CPE_FETCH_MISALIGN_EN
            fault_pend <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                pcq[i]        <= '0;
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            if (grant) begin
                pcq[pcq_wp] <= fetch_pc;
                pcq_wp      <= pcq_wp + PW'(1);
                fetch_pc    <= fetch_pc + ADDR_W'(4);
            end
            if (rsp) pcq_rp <= pcq_rp + PW'(1);
            out_cnt <= out_cnt + CW'(grant) - CW'(rsp);

            if (push) begin
                fifo_instr[fifo_wp] <= imem_rdata_w_i;
                fifo_pc[fifo_wp]    <= pcq[pcq_rp];
                fifo_wp             <= fifo_wp + PW'(1);
            end
            if (pop) fifo_rp <= fifo_rp + PW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);

            if (state == S_DRAIN) begin
                if (imem_rvalid_w_i_h && disc_cnt != '0) disc_cnt <= disc_cnt - CW'(1);
                if (disc_cnt == '0 || (imem_rvalid_w_i_h && disc_cnt == CW'(1)))
                    state <= settle_st;
            end

            // redirect overrides the queue updates above; a same-cycle pop was already seen by the consumer
            if (redirect_w_i_h) begin
                fetch_pc <= redir_pc;
`ifdef CPE_FETCH_MISALIGN_EN
                fault_pend <= redir_mis;
`endif
                if (state != S_DRAIN) begin
                    out_cnt  <= '0;
                    fifo_cnt <= '0;
                    pcq_wp   <= '0;
                    pcq_rp   <= '0;
                    fifo_wp  <= '0;
                    fifo_rp  <= '0;
                    disc_cnt <= disc_load;
                    state    <= (disc_load != '0) ? S_DRAIN : settle_st;
                end
            end
        end
    end
endmodule
